// File: rtl/bsg_manycore_sdr_link_pkg.sv
// Shared sizing helpers for the manycore SDR link multiplexer.
// Width rules for the credit counters and the channel-id field.
package bsg_manycore_sdr_link_pkg;

   function automatic int credit_width(input int lg_fifo_depth);
      return lg_fifo_depth + 1;
   endfunction

   function automatic int ch_width(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/bsg_manycore_sdr_link_credit_counter.sv
// Per-channel send credit counter: decrement on send, add a token's worth on return.
// The count saturates at the far-end FIFO depth and reports overflow beyond it.
module bsg_manycore_sdr_link_credit_counter
   import bsg_manycore_sdr_link_pkg::*;
#(
   parameter int lg_fifo_depth_p                 = 3,
   parameter int lg_credit_to_token_decimation_p = 1
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic decr_i,
   input  logic token_i,
   output logic nonzero_o,
   output logic overflow_o
);

   localparam int cw_lp = credit_width(lg_fifo_depth_p);
   localparam logic [cw_lp:0] max_lp  = (cw_lp+1)'(2**lg_fifo_depth_p);
   localparam logic [cw_lp:0] step_lp = (cw_lp+1)'(2**lg_credit_to_token_decimation_p);

   logic [cw_lp-1:0] count_r;
   logic [cw_lp:0]   sum;
   logic [cw_lp-1:0] count_n;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      sum = {1'b0, count_r};
      if (token_i) sum = sum + step_lp;
      if (decr_i)  sum = sum - 1'b1;
      overflow_o = (sum > max_lp);
      count_n    = overflow_o ? max_lp[cw_lp-1:0] : sum[cw_lp-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) count_r <= max_lp[cw_lp-1:0];
      else            count_r <= count_n;
   end

   assign nonzero_o = |count_r;

endmodule

// File: rtl/bsg_manycore_sdr_link_mux.sv
// Credit-flow-controlled SDR link endpoint multiplexing N channels onto one bundle.
// Optional BSG_MANYCORE_SDR_LINK_MUX_ERROR_CHECK_EN enables the sticky error_o and its assertions.
module bsg_manycore_sdr_link_mux
   import bsg_manycore_sdr_link_pkg::*;
#(
   parameter int width_p                          = 32,
   parameter int num_channels_p                   = 2,
   parameter int lg_fifo_depth_p                  = 3,
   parameter int lg_credit_to_token_decimation_p  = 1,
   localparam int ch_width_lp                     = ch_width(num_channels_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_channels_p*width_p-1:0]   core_data_i,
   input  logic [num_channels_p-1:0]           core_v_i,
   output logic [num_channels_p-1:0]           core_ready_and_o,
   output logic [num_channels_p*width_p-1:0]   core_data_o,
   output logic [num_channels_p-1:0]           core_v_o,
   input  logic [num_channels_p-1:0]           core_yumi_i,
   output logic [width_p-1:0]                  link_data_o,
   output logic [ch_width_lp-1:0]              link_ch_o,
   output logic                                link_v_o,
   input  logic [num_channels_p-1:0]           link_token_i,
   input  logic [width_p-1:0]                  link_data_i,
   input  logic [ch_width_lp-1:0]              link_ch_i,
   input  logic                                link_v_i,
   output logic [num_channels_p-1:0]           link_token_o,
   output logic                                error_o
);

   localparam int fifo_els_lp = 2**lg_fifo_depth_p;

   logic [num_channels_p-1:0] credit_nz, credit_overflow, eligible, grant;
   logic [num_channels_p-1:0] ch_hit, fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [ch_width_lp-1:0]    ptr_r, grant_id;
   logic                      arb_found;
   int                        arb_idx;

   assign eligible         = core_v_i & credit_nz;
   assign core_ready_and_o = grant;

   // Round-robin: search upward from the pointer with wrap, first eligible wins.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      arb_found = 1'b0;
      arb_idx   = 0;
      for (int k = 0; k < num_channels_p; k++) begin
         arb_idx = (int'(ptr_r) + k) % num_channels_p;
         if (!arb_found && eligible[arb_idx]) begin
            arb_found        = 1'b1;
            grant[arb_idx]   = 1'b1;
            grant_id         = ch_width_lp'(arb_idx);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ptr_r       <= '0;
         link_v_o    <= 1'b0;
         link_data_o <= '0;
         link_ch_o   <= '0;
      end else begin
         link_v_o <= arb_found;
         if (arb_found) begin
            ptr_r       <= (grant_id == ch_width_lp'(num_channels_p-1)) ? '0 : grant_id + 1'b1;
            link_data_o <= core_data_i[int'(grant_id)*width_p +: width_p];
            link_ch_o   <= grant_id;
         end
      end
   end

   for (genvar i = 0; i < num_channels_p; i++) begin : g_ch
      bsg_manycore_sdr_link_credit_counter #(
         .lg_fifo_depth_p                (lg_fifo_depth_p),
         .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
      ) credit (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .decr_i    (grant[i]),
         .token_i   (link_token_i[i]),
         .nonzero_o (credit_nz[i]),
         .overflow_o(credit_overflow[i])
      );

      // Receive FIFO; a pop frees its slot before the full check so a full FIFO can accept.
      logic [width_p-1:0]         mem [fifo_els_lp];
      logic [lg_fifo_depth_p-1:0] wr_ptr_r, rd_ptr_r;
      logic [lg_fifo_depth_p:0]   count_r;
      logic                       token_r;

      assign ch_hit[i]     = link_v_i && (link_ch_i == ch_width_lp'(i));
      assign fifo_full[i]  = (count_r == (lg_fifo_depth_p+1)'(fifo_els_lp));
      assign fifo_empty[i] = (count_r == '0);
      assign fifo_pop[i]   = core_yumi_i[i] && !fifo_empty[i];
      assign fifo_push[i]  = ch_hit[i] && (!fifo_full[i] || fifo_pop[i]);

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
         end else begin
            if (fifo_push[i]) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (fifo_pop[i])  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({fifo_push[i], fifo_pop[i]})
               2'b10:   count_r <= count_r + 1'b1;
               2'b01:   count_r <= count_r - 1'b1;
               default: count_r <= count_r;
            endcase
         end
      end

      // NOTE: storage is deliberately not reset; emptiness is owned by the reset pointers.
      always_ff @(posedge clk_i) begin
         if (fifo_push[i]) mem[wr_ptr_r] <= link_data_i;
      end

      assign core_data_o[i*width_p +: width_p] = mem[rd_ptr_r];
      assign core_v_o[i]     = !fifo_empty[i];
      assign link_token_o[i] = token_r;

      if (lg_credit_to_token_decimation_p == 0) begin : g_nodec
         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) token_r <= 1'b0;
            else            token_r <= fifo_pop[i];
         end
      end else begin : g_dec
         logic [lg_credit_to_token_decimation_p-1:0] consume_r;
         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               consume_r <= '0;
               token_r   <= 1'b0;
            end else begin
               if (fifo_pop[i]) consume_r <= consume_r + 1'b1;
               token_r <= fifo_pop[i] && (&consume_r);
            end
         end
      end
   end

`ifdef BSG_MANYCORE_SDR_LINK_MUX_ERROR_CHECK_EN
   logic [num_channels_p-1:0] drop_full, yumi_empty;
   logic                      ch_oor, err_now, error_r;

   assign drop_full  = ch_hit & fifo_full & ~fifo_pop;
   assign yumi_empty = core_yumi_i & fifo_empty;
   assign ch_oor     = link_v_i && (32'(link_ch_i) >= 32'(num_channels_p));
   assign err_now    = (|credit_overflow) || (|drop_full) || (|yumi_empty) || ch_oor;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)   error_r <= 1'b0;
      else if (err_now) error_r <= 1'b1;
   end

   assign error_o = error_r;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(|credit_overflow)) else $warning("sdr link: credit overflow");
         assert (!(|drop_full))       else $warning("sdr link: write to full receive fifo");
         assert (!ch_oor)             else $warning("sdr link: channel id out of range");
         assert (!(|yumi_empty))      else $warning("sdr link: yumi on empty fifo");
      end
   end
`endif
`else
   logic unused_overflow;
   assign unused_overflow = |credit_overflow;
   assign error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_sdr_link_mux.sv
// Directed bench for bsg_manycore_sdr_link_mux: N=2, width 8, depth 8, decimation 2.
module tb_bsg_manycore_sdr_link_mux;

   localparam int w_lp = 8;
   localparam int n_lp = 2;

`ifdef BSG_MANYCORE_SDR_LINK_MUX_ERROR_CHECK_EN
   localparam logic exp_err_lp = 1'b1;
`else
   localparam logic exp_err_lp = 1'b0;
`endif

   logic                  clk_i = 1'b0;
   logic                  reset_n_i;
   logic [n_lp*w_lp-1:0]  core_data_i;
   logic [n_lp-1:0]       core_v_i;
   logic [n_lp-1:0]       core_ready_and_o;
   logic [n_lp*w_lp-1:0]  core_data_o;
   logic [n_lp-1:0]       core_v_o;
   logic [n_lp-1:0]       core_yumi_i;
   logic [w_lp-1:0]       link_data_o;
   logic [0:0]            link_ch_o;
   logic                  link_v_o;
   logic [n_lp-1:0]       link_token_i;
   logic [w_lp-1:0]       link_data_i;
   logic [0:0]            link_ch_i;
   logic                  link_v_i;
   logic [n_lp-1:0]       link_token_o;
   logic                  error_o;

   bsg_manycore_sdr_link_mux #(
      .width_p                        (w_lp),
      .num_channels_p                 (n_lp),
      .lg_fifo_depth_p                (3),
      .lg_credit_to_token_decimation_p(1)
   ) dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .core_data_i     (core_data_i),
      .core_v_i        (core_v_i),
      .core_ready_and_o(core_ready_and_o),
      .core_data_o     (core_data_o),
      .core_v_o        (core_v_o),
      .core_yumi_i     (core_yumi_i),
      .link_data_o     (link_data_o),
      .link_ch_o       (link_ch_o),
      .link_v_o        (link_v_o),
      .link_token_i    (link_token_i),
      .link_data_i     (link_data_i),
      .link_ch_i       (link_ch_i),
      .link_v_i        (link_v_i),
      .link_token_o    (link_token_o),
      .error_o         (error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0] core_v;
      logic [1:0] tok;
      logic       lv;
      logic       lch;
      logic [7:0] ldata;
      logic [1:0] yumi;
      logic [1:0] exp_ready;
      logic       chk_rd;
      logic [7:0] exp_rd1;
      logic       exp_lv;
      logic       exp_lch;
      logic [7:0] exp_ldata;
      logic [1:0] exp_core_v;
      logic [1:0] exp_tok;
   } vec_t;

   vec_t vecs [14];
   int   checks = 0;
   int   errors = 0;
   int   sends, pulses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic clear_inputs();
      core_data_i  = {8'hB1, 8'hA0};
      core_v_i     = '0;
      core_yumi_i  = '0;
      link_token_i = '0;
      link_data_i  = '0;
      link_ch_i    = '0;
      link_v_i     = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      clear_inputs();
      @(negedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Holds channel 0 valid with no tokens and counts accepted sends and link pulses.
   task automatic count_sends(output int s, output int p);
      s = 0;
      p = 0;
      core_v_i = 2'b01;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (core_ready_and_o[0]) s++;
         @(posedge clk_i);
         #1;
         if (link_v_o) p++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            core_v tok   lv    lch   ldata  yumi   rdy    chk   rd1    lv_o  ch_o  data_o  cv_o   tok_o
      vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00};
      vecs[1]  = '{2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA0, 2'b00, 2'b00};
      vecs[2]  = '{2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 2'b00, 2'b00};
      vecs[3]  = '{2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA0, 2'b00, 2'b00};
      vecs[4]  = '{2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 2'b00, 2'b00};
      vecs[5]  = '{2'b11, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA0, 2'b00, 2'b00};
      vecs[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b10, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 2'b00, 2'b00};
      vecs[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h11, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00};
      vecs[8]  = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h22, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00};
      vecs[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 8'h33, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00};
      vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00};
      vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2'b10, 2'b10};
      vecs[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00};
      vecs[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00};

      // Reset values while reset is held.
      reset_n_i = 1'b0;
      clear_inputs();
      #12;
      check("rst_link_v",    64'(link_v_o),     64'd0);
      check("rst_link_data", 64'(link_data_o),  64'd0);
      check("rst_link_ch",   64'(link_ch_o),    64'd0);
      check("rst_token",     64'(link_token_o), 64'd0);
      check("rst_core_v",    64'(core_v_o),     64'd0);
      check("rst_error",     64'(error_o),      64'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Table: round-robin alternation, token return, receive and token decimation.
      for (int v = 0; v < 14; v++) begin
         core_v_i     = vecs[v].core_v;
         link_token_i = vecs[v].tok;
         link_v_i     = vecs[v].lv;
         link_ch_i    = vecs[v].lch;
         link_data_i  = vecs[v].ldata;
         core_yumi_i  = vecs[v].yumi;
         #1;
         check($sformatf("v%0d_ready", v), 64'(core_ready_and_o), 64'(vecs[v].exp_ready));
         if (vecs[v].chk_rd)
            check($sformatf("v%0d_rdata1", v), 64'(core_data_o[15:8]), 64'(vecs[v].exp_rd1));
         @(posedge clk_i);
         #1;
         check($sformatf("v%0d_link_v", v), 64'(link_v_o), 64'(vecs[v].exp_lv));
         if (vecs[v].exp_lv) begin
            check($sformatf("v%0d_link_ch", v),   64'(link_ch_o),   64'(vecs[v].exp_lch));
            check($sformatf("v%0d_link_data", v), 64'(link_data_o), 64'(vecs[v].exp_ldata));
         end
         check($sformatf("v%0d_core_v", v),  64'(core_v_o),     64'(vecs[v].exp_core_v));
         check($sformatf("v%0d_token", v),   64'(link_token_o), 64'(vecs[v].exp_tok));
         check($sformatf("v%0d_error", v),   64'(error_o),      64'd0);
      end
      clear_inputs();

      // Credit exhaustion: exactly 8 sends on a fresh channel, then ready drops.
      apply_reset();
      count_sends(sends, pulses);
      check("credit_sends",  64'(sends),  64'd8);
      check("credit_pulses", 64'(pulses), 64'd8);
      #1;
      check("credit_ready_0", 64'(core_ready_and_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Token at zero credit: usable next cycle, link_v_o one cycle after that.
      link_token_i = 2'b01;
      #1;
      check("tok_ready_t", 64'(core_ready_and_o), 64'd0);
      @(posedge clk_i);
      #1;
      link_token_i = 2'b00;
      #1;
      check("tok_ready_t1",  64'(core_ready_and_o), 64'b01);
      check("tok_link_v_t1", 64'(link_v_o),         64'd0);
      @(posedge clk_i);
      #1;
      check("tok_link_v_t2",  64'(link_v_o),  64'd1);
      check("tok_link_ch_t2", 64'(link_ch_o), 64'd0);
      clear_inputs();

      // Overfill channel 0: the ninth packet is dropped.
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         link_v_i    = 1'b1;
         link_ch_i   = 1'b0;
         link_data_i = (i == 8) ? 8'hEE : 8'(i);
         @(posedge clk_i);
         #1;
      end
      link_v_i = 1'b0;
      check("full_core_v", 64'(core_v_o), 64'b01);
      check("full_error",  64'(error_o),  64'(exp_err_lp));
      @(posedge clk_i);
      #1;
      check("full_error_sticky", 64'(error_o), 64'(exp_err_lp));

      // Write into the full FIFO while popping: the write is accepted.
      link_v_i    = 1'b1;
      link_data_i = 8'h99;
      core_yumi_i = 2'b01;
      #1;
      check("full_pop_head", 64'(core_data_o[7:0]), 64'd0);
      @(posedge clk_i);
      #1;
      link_v_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         core_yumi_i = 2'b01;
         #1;
         check($sformatf("drain_%0d", i), 64'(core_data_o[7:0]), (i < 7) ? 64'(i + 1) : 64'h99);
         @(posedge clk_i);
         #1;
      end
      core_yumi_i = 2'b00;
      check("drain_empty",       64'(core_v_o), 64'd0);
      check("drain_error_final", 64'(error_o),  64'(exp_err_lp));

      // Reset mid-stream clears outputs immediately and restores credits.
      apply_reset();
      core_v_i    = 2'b11;
      link_v_i    = 1'b1;
      link_ch_i   = 1'b1;
      link_data_i = 8'h5A;
      @(posedge clk_i);
      #1;
      link_v_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("mid_link_v_pre", 64'(link_v_o), 64'd1);
      check("mid_core_v_pre", 64'(core_v_o), 64'b10);
      #1;
      reset_n_i = 1'b0;
      #1;
      check("mid_link_v",    64'(link_v_o),    64'd0);
      check("mid_link_data", 64'(link_data_o), 64'd0);
      check("mid_core_v",    64'(core_v_o),    64'd0);
      check("mid_error",     64'(error_o),     64'd0);
      clear_inputs();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      count_sends(sends, pulses);
      check("mid_credit_sends",  64'(sends),  64'd8);
      check("mid_credit_pulses", 64'(pulses), 64'd8);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bsg_manycore_sdr_link_mux.md
# bsg_manycore_sdr_link_mux

Multi-channel, credit-flow-controlled SDR link endpoint in a single clock domain. It multiplexes `num_channels_p` manycore link channels (e.g. fwd and rev, or several virtual networks) onto one shared valid/data/channel-id wire bundle. It also demultiplexes the same bundle on receive into per-channel buffers, with per-channel token return. It sits between manycore edge tiles and the chip-level SDR pad/IO logic, and replaces one physical link per channel.

## Interface
- `width_p`, none (must be set), payload width per packet
- `num_channels_p`, 2, number of logical channels; ≥1
- `lg_fifo_depth_p`, 3, log2 of the receive FIFO depth per channel, which is also the initial credits per channel
- `lg_credit_to_token_decimation_p`, 1, log2 of the credits represented by one token pulse; must be < `lg_fifo_depth_p`
- `clk_i` in 1: sole clock
- `reset_n_i` in 1: reset, asynchronous, active-low
- `core_data_i` in `num_channels_p*width_p`: per-channel send payload
- `core_v_i` in `num_channels_p`: per-channel send valid
- `core_ready_and_o` out `num_channels_p`: per-channel send accept
- `core_data_o` out `num_channels_p*width_p`: per-channel receive payload (FIFO head)
- `core_v_o` out `num_channels_p`: per-channel receive valid
- `core_yumi_i` in `num_channels_p`: per-channel receive consume
- `link_data_o` out `width_p`, `link_ch_o` out `$clog2(num_channels_p)` (min 1), `link_v_o` out 1: outbound bundle
- `link_token_i` in `num_channels_p`: per-channel token pulse from the far end
- `link_data_i` in `width_p`, `link_ch_i` in `$clog2(num_channels_p)` (min 1), `link_v_i` in 1: inbound bundle
- `link_token_o` out `num_channels_p`: per-channel token pulse to the far end
- `error_o` out 1: sticky protocol error (see Configuration)

## Operation
- Send credits: one counter per channel, width `lg_fifo_depth_p+1`, reset to 2^`lg_fifo_depth_p`.
- Eligible(i) = `core_v_i[i]` and credit(i) ≠ 0.
- Round-robin arbiter over eligible channels. Priority starts at the pointer, then ascends with wrap. Pointer resets to 0. After a grant to channel g, the pointer becomes (g+1) mod N.
- `core_ready_and_o[i]` = grant(i), so at most one channel has ready high per cycle. Ready never depends on `core_v_i[i]` of the same channel being deasserted later; the handshake is valid-then-ready.
- On handshake: the outbound registers capture data and channel id; credit(g) decrements.
- `link_token_i[i]` pulse: credit(i) += 2^`lg_credit_to_token_decimation_p`. On a simultaneous send on channel i, the net change is −1 + 2^dec in the same cycle.
- Credit arithmetic saturates at 2^`lg_fifo_depth_p`. Exceeding that value is an overflow error.
- Receive: `link_v_i` writes `link_data_i` into FIFO[`link_ch_i`]. Writing a full FIFO drops the packet; this is an error. A `link_ch_i` ≥ N is also dropped and flagged as an error.
- `core_v_o[i]` = FIFO[i] not empty. `core_yumi_i[i]` pops FIFO[i]. Yumi while empty is illegal.
- Token generation: each channel has a consume counter of width `lg_credit_to_token_decimation_p`, reset 0, incremented on yumi with wrap. When it wraps, `link_token_o[i]` pulses high for exactly one cycle.

## Timing
- Reset values: `link_v_o`=0, `link_data_o`=0, `link_ch_o`=0, `link_token_o`=0, `core_v_o`=0, `error_o`=0. FIFOs are empty and the pointer is 0.
- Send latency: a handshake in cycle t produces `link_v_o` high in t+1. Full throughput is one packet per cycle across all channels.
- Credit update is registered. A token arriving in cycle t makes the credit usable at t+1.
- Receive latency: `link_v_i` in cycle t gives `core_v_o` high at t+1.
- Write and pop on the same FIFO in the same cycle are allowed. This holds at full occupancy only if the pop is applied before the full check, i.e. a full FIFO with a simultaneous pop accepts the write.
- Token latency: the yumi that completes the decimation group in cycle t drives `link_token_o` high in t+1 (registered).
- Reset assertion mid-transfer clears everything immediately, including in-flight FIFO contents and partial consume counts. Both ends must be reset together.

## Configuration
- `BSG_MANYCORE_SDR_LINK_MUX_ERROR_CHECK_EN` defined:
  - `error_o` sets on credit overflow, a receive write to a full FIFO, an out-of-range `link_ch_i`, or yumi on an empty FIFO.
  - Once set, it stays set until reset.
  - Simulation assertions fire on the same conditions.
- Undefined: the error logic is removed and `error_o` is tied 0. The drop behaviour is unchanged.

## Structure
- Package `bsg_manycore_sdr_link_pkg` holds:
  - a credit-width function, `lg_fifo_depth_p+1`;
  - the channel-id width constant rule, `max(1,$clog2(N))`.
- Sub-module `bsg_manycore_sdr_link_credit_counter`: one per channel. It provides the saturating credit counter with decrement/token inputs, a nonzero output and an overflow output.
- Receive buffering reuses the existing small 1r1w FIFO.

## Test plan
- Reset, N=2, depth 8, dec 1: all outputs are 0 and credits are 8. Hold `core_v_i[0]`=1 with no tokens → exactly 8 packets emitted, then `core_ready_and_o[0]`=0.
- Both channels valid continuously with tokens returned → `link_ch_o` alternates 0,1,0,1.
- Channel 0 at credit 0, then a `link_token_i[0]` pulse in cycle t → channel 0 sends in cycle t+1 and `link_v_o` is high at t+2.
- Inbound 3 packets on channel 1, then yumi all → `link_token_o[1]` pulses once, one cycle after the 2nd yumi; no pulse after the 3rd.
- Write 9 packets to channel 0 with no yumi, `ERROR_CHECK_EN` defined → the 9th is dropped and `error_o`=1 stays set until reset.
- Assert `reset_n_i` low mid-stream → `link_v_o` goes 0 immediately and credits return to 8 on release.
